// File: rtl/prog_feeder_pkg.sv
// prog_feeder_pkg -- shared types and constants for the program feeder.
//   state_t     : controller states (S_FAULT exists only with PROG_FEEDER_TIMEOUT_EN)
//   OPC_MVI     : opcode whose following word is an immediate operand
//   OPC_HALT    : opcode that stops execution without issuing
//   TIMEOUT_MAX : watchdog limit on WAIT cycles (PROG_FEEDER_TIMEOUT_EN only)
package prog_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_IMM   = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4
`ifdef PROG_FEEDER_TIMEOUT_EN
        ,
        S_FAULT = 3'd5
`endif
    } state_t;

    localparam logic [2:0] OPC_MVI     = 3'b001;
    localparam logic [2:0] OPC_HALT    = 3'b111;
    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/prog_feeder_ram.sv
// prog_ram -- program memory: one synchronous write port, two asynchronous
// reads (at i_raddr and at i_raddr+1, wrapping). Contents have no reset.
//   i_clk      : clock
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write data
//   i_raddr    : read address
//   o_rdata    : mem[i_raddr]
//   o_rdata_nx : mem[i_raddr+1 mod 2^ADDR_W]
module prog_ram
    import prog_feeder_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_rdata_nx
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_raddr_nx;

    assign w_raddr_nx = i_raddr + ADDR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata    = r_mem[i_raddr];
    assign o_rdata_nx = r_mem[w_raddr_nx];

endmodule

// File: rtl/prog_feeder.sv
// prog_feeder -- steps a small program memory and feeds instruction words
// (and mvi immediates) to a processor, waiting on Done between instructions.
// Optional macro PROG_FEEDER_TIMEOUT_EN adds a WAIT watchdog and FAULT state.
//   Clock, Reset          : clock, synchronous active-high reset
//   LdEn, LdAddr, LdData  : program load port (accepted in IDLE/HALT only)
//   Start                 : begin at address 0 (from IDLE/HALT/FAULT)
//   Done                  : processor finished current instruction (WAIT only)
//   DIN, Run              : word to processor, one-cycle issue pulse
//   PC                    : address of instruction in flight
//   Busy, Halted          : status
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    input  logic              Start,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_din;
    logic              r_mvi;
`ifdef PROG_FEEDER_TIMEOUT_EN
    logic [7:0]        r_wdog;
`endif

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_word_nx;
    logic [2:0]        w_opc;
    logic              w_we;

    assign w_opc = w_word[DATA_W-1 -: 3];
    assign w_we  = LdEn && ((r_state == S_IDLE) || (r_state == S_HALT));

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk      (Clock),
        .i_we       (w_we),
        .i_waddr    (LdAddr),
        .i_wdata    (LdData),
        .i_raddr    (r_pc),
        .o_rdata    (w_word),
        .o_rdata_nx (w_word_nx)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_din   <= '0;
            r_mvi   <= 1'b0;
`ifdef PROG_FEEDER_TIMEOUT_EN
            r_wdog  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALT
`ifdef PROG_FEEDER_TIMEOUT_EN
                , S_FAULT
`endif
                : begin
                    if (Start) begin
                        r_pc    <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_din <= w_word;
`ifdef PROG_FEEDER_TIMEOUT_EN
                    r_wdog <= '0;
`endif
                    if (w_opc == OPC_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_opc == OPC_MVI) begin
                        r_mvi   <= 1'b1;
                        r_state <= S_IMM;
                    end else begin
                        r_mvi   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_IMM: begin
                    r_din   <= w_word_nx;
                    r_state <= S_WAIT;
`ifdef PROG_FEEDER_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (Done) begin
                        r_pc    <= r_pc + (r_mvi ? ADDR_W'(2) : ADDR_W'(1));
                        r_state <= S_ISSUE;
                    end
`ifdef PROG_FEEDER_TIMEOUT_EN
                    // 255th consecutive WAIT cycle without Done ends in FAULT
                    else if (r_wdog == TIMEOUT_MAX - 8'd1) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ISSUE/IMM present the memory word directly so a same-edge write or PC
    // update is visible with no latency; other states replay the last word.
    always_comb begin
        DIN = r_din;
        Run = 1'b0;
        case (r_state)
            S_ISSUE: begin
                DIN = w_word;
                Run = (w_opc != OPC_HALT);
            end
            S_IMM:   DIN = w_word_nx;
            default: ;
        endcase
    end

    assign PC   = r_pc;
    assign Busy = (r_state == S_ISSUE) || (r_state == S_IMM) || (r_state == S_WAIT);
`ifdef PROG_FEEDER_TIMEOUT_EN
    assign Halted = (r_state == S_HALT) || (r_state == S_FAULT);
`else
    assign Halted = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_prog_feeder.sv
module tb_prog_feeder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        LdEn = 1'b0;
    logic [4:0]  LdAddr = '0;
    logic [15:0] LdData = '0;
    logic        Start = 1'b0;
    logic        Done = 1'b0;
    logic [15:0] DIN;
    logic        Run;
    logic [4:0]  PC;
    logic        Busy;
    logic        Halted;

    int n_pass = 0;
    int n_checks = 0;

    logic [15:0] model_mem [32];
    logic [4:0]  exp_pc[$];
    logic [15:0] exp_word[$];
    logic [15:0] exp_imm[$];
    logic        exp_halted;
    logic [4:0]  exp_halt_pc;

    logic [4:0]  obs_pc[$];
    logic [15:0] obs_word[$];
    logic [15:0] obs_imm[$];
    logic        obs_halted;
    logic        obs_run_halt;
    logic        obs_timeout;

    prog_feeder #(.ADDR_W(5), .DATA_W(16)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .LdEn   (LdEn),
        .LdAddr (LdAddr),
        .LdData (LdData),
        .Start  (Start),
        .Done   (Done),
        .DIN    (DIN),
        .Run    (Run),
        .PC     (PC),
        .Busy   (Busy),
        .Halted (Halted)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        LdEn = 1'b1; LdAddr = 5'(a); LdData = d;
        tick();
        LdEn = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    // Architectural walk of the program: what gets issued, in what order.
    task automatic model_walk(input int max_issues);
        int pc;
        logic [15:0] w;
        exp_pc.delete(); exp_word.delete(); exp_imm.delete();
        exp_halted = 1'b0; exp_halt_pc = '0;
        pc = 0;
        for (int n = 0; n < max_issues; n++) begin
            w = model_mem[pc];
            if (w[15:13] == 3'b111) begin
                exp_halted = 1'b1; exp_halt_pc = 5'(pc);
                break;
            end
            exp_pc.push_back(5'(pc));
            exp_word.push_back(w);
            if (w[15:13] == 3'b001) begin
                exp_imm.push_back(model_mem[(pc + 1) % 32]);
                pc = (pc + 2) % 32;
            end else begin
                exp_imm.push_back(16'h0);
                pc = (pc + 1) % 32;
            end
        end
    endtask

    // Starts the program and plays the processor; records what was issued.
    task automatic execute(input int max_issues, input int dmin, input int dmax, input bit noise);
        int phase, wc, delay;
        obs_pc.delete(); obs_word.delete(); obs_imm.delete();
        obs_halted = 1'b0; obs_run_halt = 1'b0; obs_timeout = 1'b1;
        phase = 0; wc = 0; delay = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            Done = 1'b0;
            if (Halted) begin
                obs_halted = 1'b1; obs_timeout = 1'b0;
                break;
            end
            if (Run) begin
                if (obs_pc.size() == max_issues) begin
                    obs_timeout = 1'b0;
                    break;
                end
                if (DIN[15:13] == 3'b111) obs_run_halt = 1'b1;
                obs_pc.push_back(PC); obs_word.push_back(DIN); obs_imm.push_back(16'h0);
                if (DIN[15:13] == 3'b001) phase = 1;
                else begin phase = 2; wc = 0; delay = int'($urandom_range(dmax, dmin)); end
                if (noise) Done = 1'($urandom_range(1, 0));
            end else if (phase == 1) begin
                obs_imm[obs_imm.size() - 1] = DIN;
                phase = 2; wc = 0; delay = int'($urandom_range(dmax, dmin));
                if (noise) Done = 1'($urandom_range(1, 0));
            end else if (phase == 2) begin
                if (wc == delay) begin Done = 1'b1; phase = 0; end
                else wc++;
            end
            tick();
        end
        Done = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; tick(); tick();
        n_checks++; if (Run !== 1'b0) $display("FAIL reset_run: got %b expected 0", Run); else n_pass++;
        n_checks++; if (DIN !== 16'h0) $display("FAIL reset_din: got %h expected 0000", DIN); else n_pass++;
        n_checks++; if (PC !== 5'd0) $display("FAIL reset_pc: got %0d expected 0", PC); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else n_pass++;
        n_checks++; if (Halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", Halted); else n_pass++;
        Reset = 1'b0;
        tick();
        n_checks++; if (Busy !== 1'b0) $display("FAIL idle_hold: busy %b expected 0", Busy); else n_pass++;
    endtask

    task automatic test_mv_halt();
        load_word(0, 16'h0000); load_word(1, 16'hE000);
        model_walk(8); execute(8, 1, 1, 0);
        n_checks++; if (obs_pc.size() !== exp_pc.size()) $display("FAIL mvhalt_count: got %0d expected %0d", obs_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i] || obs_imm[i] !== exp_imm[i])
                $display("FAIL mvhalt_issue%0d: got pc %0d w %h imm %h expected pc %0d w %h imm %h", i, obs_pc[i], obs_word[i], obs_imm[i], exp_pc[i], exp_word[i], exp_imm[i]);
            else n_pass++;
        end
        n_checks++; if (obs_halted !== exp_halted || PC !== exp_halt_pc) $display("FAIL mvhalt_halt: got halted %b pc %0d expected %b pc %0d", obs_halted, PC, exp_halted, exp_halt_pc); else n_pass++;
        n_checks++; if (obs_run_halt !== 1'b0 || Run !== 1'b0 || Busy !== 1'b0) $display("FAIL mvhalt_noissue: got runhalt %b run %b busy %b expected 0 0 0", obs_run_halt, Run, Busy); else n_pass++;
    endtask

    task automatic test_mvi();
        load_word(0, 16'h2000); load_word(1, 16'h00A5); load_word(2, 16'hE000);
        model_walk(8); execute(8, 2, 2, 0);
        n_checks++; if (obs_pc.size() !== exp_pc.size()) $display("FAIL mvi_count: got %0d expected %0d", obs_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i] || obs_imm[i] !== exp_imm[i])
                $display("FAIL mvi_issue%0d: got pc %0d w %h imm %h expected pc %0d w %h imm %h", i, obs_pc[i], obs_word[i], obs_imm[i], exp_pc[i], exp_word[i], exp_imm[i]);
            else n_pass++;
        end
        n_checks++; if (obs_halted !== 1'b1 || PC !== 5'd2) $display("FAIL mvi_halt: got halted %b pc %0d expected 1 pc 2", obs_halted, PC); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < 30; a++)
                load_word(a, {3'($urandom_range(6, 0)), 13'($urandom)});
            load_word(30, {3'b111, 13'($urandom)});
            load_word(31, {3'b111, 13'($urandom)});
            model_walk(64); execute(64, 0, 4, 1);
            n_checks++; if (obs_timeout !== 1'b0 || obs_pc.size() !== exp_pc.size()) $display("FAIL rand%0d_count: got %0d timeout %b expected %0d", it, obs_pc.size(), obs_timeout, exp_pc.size()); else n_pass++;
            for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
                n_checks++;
                if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i] || obs_imm[i] !== exp_imm[i])
                    $display("FAIL rand%0d_issue%0d: got pc %0d w %h imm %h expected pc %0d w %h imm %h", it, i, obs_pc[i], obs_word[i], obs_imm[i], exp_pc[i], exp_word[i], exp_imm[i]);
                else n_pass++;
            end
            n_checks++; if (obs_halted !== 1'b1 || PC !== exp_halt_pc || obs_run_halt !== 1'b0) $display("FAIL rand%0d_halt: got halted %b pc %0d runhalt %b expected 1 pc %0d 0", it, obs_halted, PC, obs_run_halt, exp_halt_pc); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 32; a++)
            load_word(a, {3'($urandom_range(6, 2)), 13'($urandom)});
        model_walk(40); execute(40, 1, 1, 0);
        n_checks++; if (obs_timeout !== 1'b0 || obs_pc.size() !== 40) $display("FAIL wrap_count: got %0d timeout %b expected 40", obs_pc.size(), obs_timeout); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i])
                $display("FAIL wrap_issue%0d: got pc %0d w %h expected pc %0d w %h", i, obs_pc[i], obs_word[i], exp_pc[i], exp_word[i]);
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_mvi_wrap();
        load_word(0, 16'h0123);
        for (int a = 1; a < 31; a++) load_word(a, 16'h4000 | 16'(a));
        load_word(31, 16'h2000);
        model_walk(33); execute(33, 0, 2, 0);
        n_checks++; if (obs_timeout !== 1'b0 || obs_pc.size() !== exp_pc.size()) $display("FAIL mviwrap_count: got %0d expected %0d", obs_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i] || obs_imm[i] !== exp_imm[i])
                $display("FAIL mviwrap_issue%0d: got pc %0d w %h imm %h expected pc %0d w %h imm %h", i, obs_pc[i], obs_word[i], obs_imm[i], exp_pc[i], exp_word[i], exp_imm[i]);
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        Start = 1'b1; tick(); Start = 1'b0;
        tick(); tick();
        n_checks++; if (Busy !== 1'b1 || Run !== 1'b0) $display("FAIL midrst_inwait: got busy %b run %b expected 1 0", Busy, Run); else n_pass++;
        Reset = 1'b1; tick();
        n_checks++;
        if (Run !== 1'b0 || DIN !== 16'h0 || PC !== 5'd0 || Busy !== 1'b0 || Halted !== 1'b0)
            $display("FAIL midrst_state: got run %b din %h pc %0d busy %b halted %b expected 0 0000 0 0 0", Run, DIN, PC, Busy, Halted);
        else n_pass++;
        Reset = 1'b0;
        model_walk(33); execute(33, 0, 1, 0);
        n_checks++; if (obs_pc.size() !== exp_pc.size()) $display("FAIL midrst_count: got %0d expected %0d", obs_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i] || obs_imm[i] !== exp_imm[i])
                $display("FAIL midrst_mem%0d: got pc %0d w %h imm %h expected pc %0d w %h imm %h", i, obs_pc[i], obs_word[i], obs_imm[i], exp_pc[i], exp_word[i], exp_imm[i]);
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_ld_in_wait();
        bit reached;
        load_word(0, 16'h0000); load_word(1, 16'h0000); load_word(2, 16'hE000);
        load_word(3, 16'h4321); load_word(4, 16'hE000);
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        LdEn = 1'b1; LdAddr = 5'd3; LdData = 16'hE000;
        tick(); tick();
        LdEn = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (Halted) begin reached = 1'b1; break; end
            Done = Busy && !Run;
            tick();
        end
        Done = 1'b0;
        n_checks++; if (reached !== 1'b1) $display("FAIL ldwait_halt: got halted %b expected 1", reached); else n_pass++;
        load_word(2, 16'h0000);
        model_walk(16); execute(16, 0, 1, 0);
        n_checks++; if (obs_pc.size() !== exp_pc.size()) $display("FAIL ldwait_count: got %0d expected %0d", obs_pc.size(), exp_pc.size()); else n_pass++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (obs_pc[i] !== exp_pc[i] || obs_word[i] !== exp_word[i])
                $display("FAIL ldwait_issue%0d: got pc %0d w %h expected pc %0d w %h", i, obs_pc[i], obs_word[i], exp_pc[i], exp_word[i]);
            else n_pass++;
        end
        n_checks++; if (obs_halted !== 1'b1 || PC !== 5'd4) $display("FAIL ldwait_end: got halted %b pc %0d expected 1 pc 4", obs_halted, PC); else n_pass++;
    endtask

    task automatic test_ld_start();
        LdEn = 1'b1; LdAddr = 5'd0; LdData = 16'h5A5A; Start = 1'b1;
        tick();
        LdEn = 1'b0; Start = 1'b0;
        model_mem[0] = 16'h5A5A;
        n_checks++;
        if (Run !== 1'b1 || DIN !== model_mem[0] || PC !== 5'd0)
            $display("FAIL ldstart_issue: got run %b din %h pc %0d expected 1 %h 0", Run, DIN, PC, model_mem[0]);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_watchdog();
        int cnt;
        load_word(0, 16'h0000);
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!Busy) break;
            cnt++;
            tick();
        end
`ifdef PROG_FEEDER_TIMEOUT_EN
        n_checks++; if (cnt !== 255) $display("FAIL wdog_cycles: got %0d expected 255", cnt); else n_pass++;
        n_checks++; if (Halted !== 1'b1 || Busy !== 1'b0 || PC !== 5'd0) $display("FAIL wdog_fault: got halted %b busy %b pc %0d expected 1 0 0", Halted, Busy, PC); else n_pass++;
        Start = 1'b1; tick(); Start = 1'b0;
        n_checks++; if (Run !== 1'b1 || PC !== 5'd0) $display("FAIL wdog_restart: got run %b pc %0d expected 1 0", Run, PC); else n_pass++;
`else
        n_checks++; if (cnt !== 1000) $display("FAIL wait_unbounded: got %0d busy cycles expected 1000", cnt); else n_pass++;
        n_checks++; if (Busy !== 1'b1 || Halted !== 1'b0 || Run !== 1'b0 || PC !== 5'd0) $display("FAIL wait_state: got busy %b halted %b run %b pc %0d expected 1 0 0 0", Busy, Halted, Run, PC); else n_pass++;
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_mv_halt();
        test_mvi();
        test_random();
        test_ld_in_wait();
        test_ld_start();
        test_wrap();
        test_mvi_wrap();
        test_reset_mid();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
